if_stage_unit: RTL

IF_STAGE_UNIT -- requirements
Module: if_stage_unit

---
 rtl/if_stage_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/if_stage_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, one-entry
// skid buffer for data that arrives while decode is stalled, and a small
// FETCH/HOLD/REDIRECT controller.
module if_stage_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_readdata,
    input  logic        imem_busywait,
    output logic        imem_read,
    output logic [31:0] imem_address,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {FETCH, HOLD, REDIRECT} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pc_plus4;
    logic [31:0] skid, skid_n;
    logic [31:0] instr_n, ipc_n, ipc4_n;
    logic        valid_n;

    // 32-bit wrap is intentional: 0xFFFF_FFFC advances to 0.
    assign pc_plus4     = pc + 32'd4;
    assign imem_address = pc;
    // Gate with RESET so no request escapes while reset is held.
    assign imem_read    = (state == FETCH) && !RESET;

    // Next-state / next-register logic; branch overrides stall and busywait.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        skid_n  = skid;
        instr_n = if_id_instruction;
        ipc_n   = if_id_pc;
        ipc4_n  = if_id_pc_plus4;
        valid_n = if_id_valid;
        if (branch_taken) begin
            // Redirect: word-align target, squash IF/ID, drop skid data.
            pc_n    = {branch_target[31:2], 2'b00};
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
            skid_n  = '0;
            state_n = REDIRECT;
        end else begin
            unique case (state)
                FETCH: begin
                    if (!imem_busywait && !stall) begin
                        instr_n = imem_readdata;
                        ipc_n   = pc;
                        ipc4_n  = pc_plus4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                    end else if (!imem_busywait && stall) begin
                        // Data is ready but decode cannot take it: park it.
                        skid_n  = imem_readdata;
                        state_n = HOLD;
                    end else if (imem_busywait && !stall) begin
                        instr_n = NOP_INSTR;
                        valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        // Release parked word without refetching it.
                        instr_n = skid;
                        ipc_n   = pc;
                        ipc4_n  = pc_plus4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                        state_n = FETCH;
                    end
                end
                REDIRECT: begin
                    // One dead cycle so any in-flight read is ignored.
                    if (!stall) begin
                        instr_n = NOP_INSTR;
                        valid_n = 1'b0;
                    end
                    state_n = FETCH;
                end
                default: state_n = FETCH;
            endcase
        end
    end

    // State, PC, skid buffer and IF/ID registers with async reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state             <= FETCH;
            pc                <= RESET_PC;
            skid              <= '0;
            if_id_instruction <= NOP_INSTR;
            if_id_pc          <= '0;
            if_id_pc_plus4    <= '0;
            if_id_valid       <= 1'b0;
        end else begin
            state             <= state_n;
            pc                <= pc_n;
            skid              <= skid_n;
            if_id_instruction <= instr_n;
            if_id_pc          <= ipc_n;
            if_id_pc_plus4    <= ipc4_n;
            if_id_valid       <= valid_n;
        end
    end

endmodule
